// File: rtl/mtimer.sv
// Machine-mode timer: free-running 64-bit mtime with prescaler, mtimecmp compare
// register, ctrl.enable and a registered level interrupt behind a req/ack register bus.
module mtimer #(
    parameter int PRESCALE          = 1,
    parameter bit IRQ_AT_RESET_MASK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        timer_irq_o
);

    localparam logic [15:0] PRESC_LAST  = 16'(PRESCALE - 1);
    localparam logic [4:0]  A_MTIME_LO  = 5'h00;
    localparam logic [4:0]  A_MTIME_HI  = 5'h04;
    localparam logic [4:0]  A_MTCMP_LO  = 5'h08;
    localparam logic [4:0]  A_MTCMP_HI  = 5'h0C;
    localparam logic [4:0]  A_CTRL      = 5'h10;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic [15:0] presc_q, presc_d;
    logic        enable_q, enable_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic accept, addr_bad, wr, rd, tick;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    always_comb begin
        accept   = req_i & ~ack_q;
        addr_bad = (addr_i[1:0] != 2'b00) || (addr_i > A_CTRL);
        wr       = accept & we_i & ~addr_bad;
        rd       = accept & ~we_i & ~addr_bad;
        tick     = enable_q && (presc_q == PRESC_LAST);

        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        hi_shadow_d = hi_shadow_q;
        presc_d     = presc_q;
        enable_d    = enable_q;
        ack_d       = accept;
        err_d       = accept & addr_bad;
        rdata_d     = '0;

        if (enable_q) begin
            presc_d = tick ? '0 : presc_q + 16'd1;
        end
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // A software write to mtime overrides the increment and restarts the prescaler.
        if (wr) begin
            case (addr_i)
                A_MTIME_LO: if (|be_i) begin
                    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_i, be_i)};
                    presc_d = '0;
                end
                A_MTIME_HI: if (|be_i) begin
                    mtime_d = {merge_bytes(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
                    presc_d = '0;
                end
                A_MTCMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_i, be_i);
                A_MTCMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, be_i);
                A_CTRL:     if (be_i[0]) enable_d = wdata_i[0];
                default: ;
            endcase
        end

        if (rd) begin
            case (addr_i)
                A_MTIME_LO: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                A_MTIME_HI: rdata_d = hi_shadow_q;
                A_MTCMP_LO: rdata_d = mtimecmp_q[31:0];
                A_MTCMP_HI: rdata_d = mtimecmp_q[63:32];
                A_CTRL:     rdata_d = {31'd0, enable_q};
                default: ;
            endcase
        end

        irq_d = enable_d & (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q     <= '0;
            mtimecmp_q  <= {64{IRQ_AT_RESET_MASK}};
            hi_shadow_q <= '0;
            presc_q     <= '0;
            enable_q    <= 1'b1;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            presc_q     <= presc_d;
            enable_q    <= enable_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: two instances (PRESCALE 1 / mask 1 and PRESCALE 4 / mask 0) driven
// by the same bus, compared every cycle against a register-level model plus directed checks.
module tb_mtimer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1, err0, err1, irq0, irq1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mtimer #(.PRESCALE(1), .IRQ_AT_RESET_MASK(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rdata_o(rdata0), .ack_o(ack0),
        .err_o(err0), .timer_irq_o(irq0)
    );

    mtimer #(.PRESCALE(4), .IRQ_AT_RESET_MASK(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rdata_o(rdata1), .ack_o(ack1),
        .err_o(err1), .timer_irq_o(irq1)
    );

    // Reference model state, one slot per instance.
    int          m_pres[2] = '{1, 4};
    bit          m_mask[2] = '{1'b1, 1'b0};
    logic [63:0] m_mtime[2];
    logic [63:0] m_cmp[2];
    logic [31:0] m_shadow[2];
    int          m_presc[2];
    bit          m_en[2];
    bit          m_ack[2];
    bit          m_err[2];
    logic [31:0] m_rdata[2];
    bit          m_irq[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] put_word(input logic [63:0] v, input int base,
                                             input logic [31:0] d, input logic [3:0] b);
        logic [63:0] r;
        r = v;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) r[base + 8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    task automatic model_step(input bit r_n, input bit rq, input bit w, input logic [4:0] a,
                              input logic [31:0] wd, input logic [3:0] bb);
        for (int i = 0; i < 2; i++) begin
            if (!r_n) begin
                m_mtime[i]  = 64'd0;
                m_cmp[i]    = m_mask[i] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
                m_shadow[i] = 32'd0;
                m_presc[i]  = 0;
                m_en[i]     = 1'b1;
                m_ack[i]    = 1'b0;
                m_err[i]    = 1'b0;
                m_rdata[i]  = 32'd0;
                m_irq[i]    = 1'b0;
            end else begin
                bit          acc, bad, nen;
                logic [63:0] nt, ncmp;
                logic [31:0] nsh, nrd;
                int          np;
                acc  = rq && !m_ack[i];
                bad  = (a % 4 != 0) || (a > 5'd16);
                nt   = m_mtime[i];
                ncmp = m_cmp[i];
                nsh  = m_shadow[i];
                nen  = m_en[i];
                np   = m_presc[i];
                nrd  = 32'd0;
                if (m_en[i]) begin
                    if (np == m_pres[i] - 1) begin
                        np = 0;
                        nt = m_mtime[i] + 64'd1;
                    end else begin
                        np = np + 1;
                    end
                end
                if (acc && !bad && w) begin
                    if (a == 5'd0 && bb != 0) begin
                        nt = put_word(m_mtime[i], 0, wd, bb);
                        np = 0;
                    end else if (a == 5'd4 && bb != 0) begin
                        nt = put_word(m_mtime[i], 32, wd, bb);
                        np = 0;
                    end else if (a == 5'd8) begin
                        ncmp = put_word(m_cmp[i], 0, wd, bb);
                    end else if (a == 5'd12) begin
                        ncmp = put_word(m_cmp[i], 32, wd, bb);
                    end else if (a == 5'd16 && bb[0]) begin
                        nen = wd[0];
                    end
                end else if (acc && !bad) begin
                    if (a == 5'd0) begin
                        nrd = m_mtime[i][31:0];
                        nsh = m_mtime[i][63:32];
                    end else if (a == 5'd4) begin
                        nrd = m_shadow[i];
                    end else if (a == 5'd8) begin
                        nrd = m_cmp[i][31:0];
                    end else if (a == 5'd12) begin
                        nrd = m_cmp[i][63:32];
                    end else begin
                        nrd = {31'd0, m_en[i]};
                    end
                end
                m_mtime[i]  = nt;
                m_cmp[i]    = ncmp;
                m_shadow[i] = nsh;
                m_presc[i]  = np;
                m_en[i]     = nen;
                m_ack[i]    = acc;
                m_err[i]    = acc && bad;
                m_rdata[i]  = nrd;
                m_irq[i]    = nen && (nt >= ncmp);
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then compare all outputs after the edge.
    task automatic cyc(input bit r_n, input bit rq, input bit w, input logic [4:0] a,
                       input logic [31:0] wd, input logic [3:0] bb);
        rst_n = r_n;
        req   = rq;
        we    = w;
        addr  = a;
        wdata = wd;
        be    = bb;
        model_step(r_n, rq, w, a, wd, bb);
        @(posedge clk);
        #1;
        chk("ack0",   ack0,   m_ack[0]);
        chk("err0",   err0,   m_err[0]);
        chk("rdata0", rdata0, m_rdata[0]);
        chk("irq0",   irq0,   m_irq[0]);
        chk("ack1",   ack1,   m_ack[1]);
        chk("err1",   err1,   m_err[1]);
        chk("rdata1", rdata1, m_rdata[1]);
        chk("irq1",   irq1,   m_irq[1]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] bb);
        cyc(1'b1, 1'b1, 1'b1, a, d, bb);
        idle(1);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] r0, output logic [31:0] r1);
        cyc(1'b1, 1'b1, 1'b0, a, 32'd0, 4'd0);
        r0 = rdata0;
        r1 = rdata1;
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r0, r1, a0, a1;
        logic [3:0]  pat;
        int          hit;
        logic [4:0]  amap[12] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14,
                                  5'h18, 5'h1C, 5'h02, 5'h01, 5'h03, 5'h11};

        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
        chk("rst_ack",   ack0,   1'b0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_irq0",  irq0,   1'b0);
        chk("rst_irq1",  irq1,   1'b0);

        // Idle 10 cycles after reset, then read mtime_lo.
        idle(10);
        chk("idle_irq0_masked", irq0, 1'b0);
        chk("idle_irq1_cmp0",   irq1, 1'b1);
        rd(5'h00, r0, r1);
        chk("idle_mtime_p1", r0, 32'd10);
        chk("idle_mtime_p4", r1, 32'd2);
        rd(5'h08, r0, r1);
        chk("rst_cmp_lo_mask1", r0, 32'hFFFF_FFFF);
        chk("rst_cmp_lo_mask0", r1, 32'd0);

        // Compare crossing with PRESCALE=4: irq rises 20 edges after the mtime write.
        wr(5'h0C, 32'd0, 4'hF);
        wr(5'h08, 32'd5, 4'hF);
        wr(5'h04, 32'd0, 4'hF);
        cyc(1'b1, 1'b1, 1'b1, 5'h00, 32'd0, 4'hF);
        chk("irq1_low_after_mtime_wr", irq1, 1'b0);
        hit = -1;
        for (int n = 1; n <= 60; n++) begin
            idle(1);
            if (irq1 && hit < 0) hit = n;
        end
        chk("irq1_rise_latency", hit, 20);
        cyc(1'b1, 1'b1, 1'b1, 5'h08, 32'd100, 4'hF);
        chk("irq1_drop_on_cmp_wr", irq1, 1'b0);
        idle(1);

        // 64-bit wrap and lo/hi shadowed read.
        wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wr(5'h00, 32'hFFFF_FFFE, 4'hF);
        rd(5'h00, r0, r1);
        chk("wrap_lo", r0, 32'hFFFF_FFFF);
        rd(5'h04, r0, r1);
        chk("wrap_hi_shadow", r0, 32'hFFFF_FFFF);
        rd(5'h00, r0, r1);
        chk("post_wrap_lo", r0, 32'd3);
        rd(5'h04, r0, r1);
        chk("post_wrap_hi", r0, 32'd0);

        // Partial write on an increment edge: no carry, no increment.
        wr(5'h04, 32'd0, 4'hF);
        wr(5'h00, 32'h1234_FFFE, 4'hF);
        wr(5'h00, 32'hAAAA_BBBB, 4'b0011);
        rd(5'h00, r0, r1);
        chk("partial_wr_lo", r0, 32'h1234_BBBC);
        rd(5'h04, r0, r1);
        chk("partial_wr_hi", r0, 32'd0);

        // Unmapped and misaligned accesses.
        cyc(1'b1, 1'b1, 1'b0, 5'h14, 32'd0, 4'd0);
        chk("err14_ack", ack0, 1'b1);
        chk("err14_err", err0, 1'b1);
        chk("err14_rd",  rdata0, 32'd0);
        idle(1);
        cyc(1'b1, 1'b1, 1'b1, 5'h02, 32'hFFFF_FFFF, 4'hF);
        chk("err02_err", err0, 1'b1);
        idle(1);

        // Held request: acks alternate.
        pat = 4'd0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 5'h10, 32'd0, 4'd0);
            pat = {pat[2:0], ack0};
        end
        chk("held_req_acks", pat, 4'b1010);
        idle(1);

        // Enable gating.
        wr(5'h0C, 32'd0, 4'hF);
        wr(5'h08, 32'd0, 4'hF);
        chk("irq0_cmp0", irq0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 5'h10, 32'd0, 4'hF);
        chk("irq0_disable", irq0, 1'b0);
        chk("irq1_disable", irq1, 1'b0);
        idle(1);
        rd(5'h00, a0, a1);
        idle(5);
        rd(5'h00, r0, r1);
        chk("frozen_p1", r0, a0);
        chk("frozen_p4", r1, a1);
        cyc(1'b1, 1'b1, 1'b1, 5'h10, 32'd1, 4'hF);
        chk("irq0_reenable", irq0, 1'b1);
        idle(1);

        // Reset while a request is presented.
        cyc(1'b0, 1'b1, 1'b0, 5'h00, 32'd0, 4'd0);
        chk("rst_mid_ack",  ack0, 1'b0);
        chk("rst_mid_irq0", irq0, 1'b0);
        chk("rst_mid_irq1", irq1, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [4:0]  ra;
            logic [31:0] rw;
            logic [3:0]  rb;
            ra = amap[$urandom_range(0, 11)];
            rw = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            if (ra == 5'h10) rw[0] = ($urandom_range(0, 3) != 0);
            if ((ra == 5'h08 || ra == 5'h00) && $urandom_range(0, 1) == 1)
                rw = $urandom_range(0, 400);
            if ((ra == 5'h0C || ra == 5'h04) && $urandom_range(0, 2) != 0)
                rw = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'd0;
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), ra, rw, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
